// File: rtl/spram_fifo_pkg.sv
// rtl/spram_fifo_pkg.sv - shared sizes and types for the single-port-RAM stream FIFO
package spram_fifo_pkg;

    localparam int AWIDTH       = 12;
    localparam int NUM_WORDS    = 4096;
    localparam int DWIDTH       = 40;
    localparam int AFULL_THRESH = 4000;
    localparam int OUTBUF_DEPTH = 2;

    // ram_level spans 0..NUM_WORDS, total level spans 0..NUM_WORDS+OUTBUF_DEPTH
    localparam int RLVL_W = AWIDTH + 1;
    localparam int LVL_W  = AWIDTH + 2;
    localparam int CNT_W  = $clog2(OUTBUF_DEPTH + 1);

    typedef logic [AWIDTH-1:0] ptr_t;
    typedef logic [RLVL_W-1:0] rlvl_t;
    typedef logic [DWIDTH-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

endpackage

// File: rtl/spram_4096_40bit.sv
// rtl/spram_4096_40bit.sv - 4096x40 single-port RAM, registered read, contents not reset
module spram_4096_40bit (
    input  logic        clk,
    input  logic        wren,
    input  logic [11:0] address,
    input  logic [39:0] data,
    output logic [39:0] q
);

    logic [39:0] r_mem [0:4095];

    // One access per cycle: write when wren, otherwise registered read (q holds across writes)
    always_ff @(posedge clk) begin
        if (wren) begin
            r_mem[address] <= data;
        end else begin
            q <= r_mem[address];
        end
    end

endmodule

// File: rtl/spram_fifo_outbuf.sv
// rtl/spram_fifo_outbuf.sv - 2-entry ordered output buffer that absorbs RAM read latency
module spram_fifo_outbuf
    import spram_fifo_pkg::*;
(
    input  logic  clk,
    input  logic  resetn,
    input  logic  i_capture,
    input  data_t i_data,
    input  logic  i_pop,
    output cnt_t  o_count,
    output data_t o_head
);

    data_t r_head;
    data_t r_tail;
    cnt_t  r_count;
    logic  w_pop;

    // A pop request against an empty buffer is ignored
    assign w_pop = i_pop && (r_count != '0);

    // Capture appends behind the current contents; pop shifts tail to head
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            case ({i_capture, w_pop})
                2'b10: begin
                    if (r_count == '0) begin
                        r_head <= i_data;
                    end else begin
                        r_tail <= i_data;
                    end
                    r_count <= r_count + 1'b1;
                end
                2'b01: begin
                    r_head  <= r_tail;
                    r_count <= r_count - 1'b1;
                end
                2'b11: begin
                    if (r_count == cnt_t'(1)) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_count = r_count;
    assign o_head  = r_head;

endmodule

// File: rtl/spram_stream_fifo.sv
// rtl/spram_stream_fifo.sv - valid/ready FIFO on one single-port RAM; SPRAM_FIFO_LEVEL_EN adds level/almost_full
module spram_stream_fifo
    import spram_fifo_pkg::*;
(
    input  logic              clk,
    input  logic              resetn,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data
`ifdef SPRAM_FIFO_LEVEL_EN
    ,
    output logic [LVL_W-1:0]  level,
    output logic              almost_full
`endif
);

    ptr_t  r_wr_ptr;
    ptr_t  r_rd_ptr;
    rlvl_t r_ram_level;
    logic  r_rd_inflight;

    cnt_t  w_buf_count;
    cnt_t  w_pending;
    logic  w_full;
    logic  w_ram_empty;
    logic  w_read_urgent;
    logic  w_wr_grant;
    logic  w_rd_grant;
    logic  w_ram_wren;
    ptr_t  w_ram_addr;
    data_t w_ram_q;

    // Words already committed to the output path: buffered plus the one being read
    assign w_pending     = w_buf_count + cnt_t'(r_rd_inflight);
    assign w_full        = (r_ram_level == rlvl_t'(NUM_WORDS));
    assign w_ram_empty   = (r_ram_level == '0);
    assign w_read_urgent = !w_ram_empty && (w_pending == '0);

    // Writes yield only when the output path would otherwise run dry
    assign in_ready   = !w_full && !w_read_urgent;
    assign w_wr_grant = in_valid && in_ready;
    assign w_rd_grant = w_read_urgent ||
                        (!w_ram_empty && (w_pending < cnt_t'(OUTBUF_DEPTH)) && !w_wr_grant);

    assign w_ram_wren = w_wr_grant;
    assign w_ram_addr = w_wr_grant ? r_wr_ptr : r_rd_ptr;

    spram_4096_40bit u_ram (
        .clk     (clk),
        .wren    (w_ram_wren),
        .address (w_ram_addr),
        .data    (in_data),
        .q       (w_ram_q)
    );

    // Pointer and occupancy bookkeeping; at most one grant per cycle so level moves by one
    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_ram_level   <= '0;
            r_rd_inflight <= 1'b0;
        end else begin
            if (w_wr_grant) begin
                r_wr_ptr    <= r_wr_ptr + 1'b1;
                r_ram_level <= r_ram_level + 1'b1;
            end else if (w_rd_grant) begin
                r_rd_ptr    <= r_rd_ptr + 1'b1;
                r_ram_level <= r_ram_level - 1'b1;
            end
            r_rd_inflight <= w_rd_grant;
        end
    end

    // RAM q is valid the cycle after a read grant; capture it then
    spram_fifo_outbuf u_outbuf (
        .clk       (clk),
        .resetn    (resetn),
        .i_capture (r_rd_inflight),
        .i_data    (w_ram_q),
        .i_pop     (out_ready),
        .o_count   (w_buf_count),
        .o_head    (out_data)
    );

    assign out_valid = (w_buf_count != '0);

`ifdef SPRAM_FIFO_LEVEL_EN
    assign level       = LVL_W'(r_ram_level) + LVL_W'(w_pending);
    assign almost_full = (level >= LVL_W'(AFULL_THRESH));
`endif

endmodule

// File: tb/tb_spram_stream_fifo.sv
// tb/tb_spram_stream_fifo.sv - directed self-checking bench for spram_stream_fifo
module tb_spram_stream_fifo;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic        in_ready;
    logic [39:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [39:0] out_data;
`ifdef SPRAM_FIFO_LEVEL_EN
    logic [13:0] level;
    logic        almost_full;
`endif

    int          n_checks;
    int          n_fail;
    int          n;
    int          k;
    int          sent;
    int          rcvd;
    logic        acc;
    logic        push;
    logic        popv;
    logic [63:0] rv;
    logic [39:0] exp_word;
    logic [39:0] sb [$];

    spram_stream_fifo dut (
        .clk         (clk),
        .resetn      (resetn),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data)
`ifdef SPRAM_FIFO_LEVEL_EN
        ,
        .level       (level),
        .almost_full (almost_full)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] fill_word(input int i);
        return {8'h5A, 32'(i) ^ 32'hA5A5_0000};
    endfunction

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        resetn    = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (3) step();
        resetn = 1'b1;
        step();

        // reset state
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_data", out_data, 0);
`ifdef SPRAM_FIFO_LEVEL_EN
        check("rst_level", level, 0);
        check("rst_afull", almost_full, 0);
`endif

        // single word latency: accepted at E0, visible after E2
        in_valid = 1'b1;
        in_data  = 40'h00_DEAD_BEEF;
        step();
        in_valid = 1'b0;
        check("lat_e0_valid", out_valid, 0);
        step();
        check("lat_e1_valid", out_valid, 0);
        step();
        check("lat_e2_valid", out_valid, 1);
        check("lat_e2_data", out_data, 40'h00_DEAD_BEEF);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("lat_popped", out_valid, 0);

        // fill with consumer stalled until in_ready stays low
        n = 0;
        for (int c = 0; c < 4300; c++) begin
            in_valid = 1'b1;
            in_data  = fill_word(n);
            acc      = in_ready;
            step();
            if (acc) n++;
`ifdef SPRAM_FIFO_LEVEL_EN
            if (acc && n == 3999) begin
                check("fill_lvl_3999", level, 3999);
                check("fill_af_3999", almost_full, 0);
            end
            if (acc && n == 4000) begin
                check("fill_lvl_4000", level, 4000);
                check("fill_af_4000", almost_full, 1);
            end
`endif
        end
        in_valid = 1'b0;
        check("fill_count", n, 4098);
        check("fill_in_ready", in_ready, 0);
        check("fill_out_valid", out_valid, 1);
        check("fill_head", out_data, fill_word(0));
`ifdef SPRAM_FIFO_LEVEL_EN
        check("fill_level", level, 4098);
        check("fill_afull", almost_full, 1);
`endif

        // drain in order, including read pointer wrap
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 12000 && k < 4098; c++) begin
            if (out_valid) begin
                check("drain_data", out_data, fill_word(k));
                k++;
            end
            step();
        end
        check("drain_count", k, 4098);
        step();
        step();
        check("drain_empty", out_valid, 0);
        check("drain_in_ready", in_ready, 1);
`ifdef SPRAM_FIFO_LEVEL_EN
        check("drain_level", level, 0);
`endif
        out_ready = 1'b0;

        // random handshakes against a scoreboard
        sent = 0;
        rcvd = 0;
        for (int c = 0; c < 20000 && rcvd < 1500; c++) begin
            if (sent < 1500 && $urandom_range(0, 1) == 1) begin
                in_valid = 1'b1;
                rv       = {$urandom, $urandom};
                in_data  = rv[39:0];
            end else begin
                in_valid = 1'b0;
            end
            out_ready = ($urandom_range(0, 1) == 1);
            push = in_valid && in_ready;
            popv = out_valid && out_ready;
            if (popv) begin
                if (sb.size() == 0) begin
                    check("rand_spurious", 1, 0);
                end else begin
                    exp_word = sb.pop_front();
                    check("rand_data", out_data, exp_word);
                end
                rcvd++;
            end
            if (push) begin
                sb.push_back(in_data);
                sent++;
            end
            step();
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        check("rand_count", rcvd, 1500);
        check("rand_sb_empty", sb.size(), 0);
        step();
        step();
        check("rand_out_idle", out_valid, 0);

        // reset while a read is in flight
        in_valid = 1'b1;
        in_data  = 40'h77_7777_7777;
        step();
        in_valid = 1'b0;
        step();
        resetn = 1'b0;
        step();
        resetn = 1'b1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_out_data", out_data, 0);
`ifdef SPRAM_FIFO_LEVEL_EN
        check("mid_rst_level", level, 0);
`endif
        step();
        step();
        check("mid_rst_discard", out_valid, 0);

        in_valid = 1'b1;
        in_data  = 40'h12_3456_789A;
        step();
        in_valid = 1'b0;
        step();
        check("post_rst_e1", out_valid, 0);
        step();
        check("post_rst_e2", out_valid, 1);
        check("post_rst_data", out_data, 40'h12_3456_789A);
        out_ready = 1'b1;
        step();
        check("post_rst_alone", out_valid, 0);
        step();
        step();
        check("post_rst_idle", out_valid, 0);
        out_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
